// File: rtl/mcs4_bus_master.sv
// mcs4_bus_master
//   CPU-side initiator of the MCS-4 4-bit multiplexed bus. Generates the
//   non-overlapping clk1/clk2 phases, sync and cmrom, and runs back-to-back
//   8-subcycle instruction cycles (A1 A2 A3 M1 M2 X1 X2 X3). Each cycle is
//   either idle or carries one host request (FETCH, or SRC/WRR/RDR I/O).
//
//   Every subcycle is split into four quarters Q0..Q3 of PHASE_TICKS sysclk
//   each: clk1 is high in Q0, clk2 is high in Q2. Responder data is sampled
//   on the last sysclk of Q2. A request is taken on the last sysclk of X3 Q3
//   and acknowledged on the last sysclk of the following cycle's X3 Q1.
//
// Ports
//   sysclk     in   system clock, all logic on posedge
//   poc_n      in   asynchronous active-low reset
//   clk1_pad   out  MCS-4 phase-1 clock
//   clk2_pad   out  MCS-4 phase-2 clock
//   sync_pad   out  high for the whole X3 subcycle
//   cmrom_pad  out  ROM/IO chip-select strobe
//   data_in    in   bus value driven by responders
//   data_out   out  bus value driven by this master (0 when not driving)
//   data_dir   out  1 = master drives the bus
//   req        in   host request; op/addr/wdata held stable while high
//   op         in   0=FETCH 1=SRC 2=WRR 3=RDR
//   addr       in   instruction address, [11:8] selects the ROM chip
//   wdata      in   SRC pair {hi,lo}; WRR uses [3:0]
//   ack        out  one-sysclk completion pulse
//   rdata      out  fetched opcode; for RDR the low nibble is the I/O value
//
// Configuration
//   MCS4_BUS_MASTER_IO_EN  defined: SRC/WRR/RDR cycles are generated.
//                          undefined: op is ignored, every request is a FETCH.

module mcs4_bus_master #(
    parameter int PHASE_TICKS = 4
) (
    input  logic        sysclk,
    input  logic        poc_n,
    output logic        clk1_pad,
    output logic        clk2_pad,
    output logic        sync_pad,
    output logic        cmrom_pad,
    input  logic [3:0]  data_in,
    output logic [3:0]  data_out,
    output logic        data_dir,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [11:0] addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic [7:0]  rdata
);

    localparam int TW = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(PHASE_TICKS - 1);

`ifdef MCS4_BUS_MASTER_IO_EN
    localparam logic IO_EN = 1'b1;
`else
    localparam logic IO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        SC_A1 = 3'd0,
        SC_A2 = 3'd1,
        SC_A3 = 3'd2,
        SC_M1 = 3'd3,
        SC_M2 = 3'd4,
        SC_X1 = 3'd5,
        SC_X2 = 3'd6,
        SC_X3 = 3'd7
    } subcycle_t;

    typedef enum logic [1:0] {
        OP_FETCH = 2'd0,
        OP_SRC   = 2'd1,
        OP_WRR   = 2'd2,
        OP_RDR   = 2'd3
    } op_t;

    logic [TW-1:0] tick_r,    tick_nxt_s;
    logic [1:0]    quarter_r, quarter_nxt_s;
    subcycle_t     sc_r,      sc_nxt_s;
    logic          active_r,  active_nxt_s;
    op_t           op_r,      op_nxt_s;
    logic [11:0]   addr_r,    addr_nxt_s;
    logic [7:0]    wdata_r,   wdata_nxt_s;

    logic          tick_last_s;
    logic          sample_s;
    logic          accept_s;
    logic          ack_edge_s;
    op_t           req_op_s;

    logic          dir_nxt_s;
    logic [3:0]    out_nxt_s;
    logic          cm_nxt_s;

    // Without I/O support every request is downgraded to a plain fetch.
    assign req_op_s = IO_EN ? op_t'(op) : OP_FETCH;

    // Next position of the tick/quarter/subcycle counters and request capture.
    always_comb begin
        tick_last_s   = (tick_r == TICK_LAST);
        sample_s      = tick_last_s && (quarter_r == 2'd2);
        accept_s      = tick_last_s && (quarter_r == 2'd3) && (sc_r == SC_X3);
        ack_edge_s    = tick_last_s && (quarter_r == 2'd1) && (sc_r == SC_X3);
        tick_nxt_s    = tick_r;
        quarter_nxt_s = quarter_r;
        sc_nxt_s      = sc_r;
        active_nxt_s  = active_r;
        op_nxt_s      = op_r;
        addr_nxt_s    = addr_r;
        wdata_nxt_s   = wdata_r;

        if (tick_last_s) begin
            tick_nxt_s    = {TW{1'b0}};
            quarter_nxt_s = quarter_r + 2'd1;
            if (quarter_r == 2'd3) begin
                // X3 + 1 wraps to A1 in the 3-bit encoding.
                sc_nxt_s = subcycle_t'(sc_r + 3'd1);
            end else begin
                sc_nxt_s = sc_r;
            end
        end else begin
            tick_nxt_s = tick_r + TW'(1);
        end

        if (accept_s) begin
            active_nxt_s = req;
            if (req) begin
                op_nxt_s    = req_op_s;
                addr_nxt_s  = addr;
                wdata_nxt_s = wdata;
            end else begin
                op_nxt_s    = op_r;
                addr_nxt_s  = addr_r;
                wdata_nxt_s = wdata_r;
            end
        end else begin
            active_nxt_s = active_r;
        end
    end

    // Bus drive and chip-select for the position the counters move into,
    // so the registered pads line up with the counters.
    always_comb begin
        dir_nxt_s = 1'b0;
        out_nxt_s = 4'd0;
        cm_nxt_s  = 1'b0;
        if (active_nxt_s) begin
            case (sc_nxt_s)
                SC_A1: begin
                    dir_nxt_s = 1'b1;
                    out_nxt_s = addr_nxt_s[3:0];
                end
                SC_A2: begin
                    dir_nxt_s = 1'b1;
                    out_nxt_s = addr_nxt_s[7:4];
                end
                SC_A3: begin
                    dir_nxt_s = 1'b1;
                    out_nxt_s = addr_nxt_s[11:8];
                    cm_nxt_s  = 1'b1;
                end
                SC_M2: begin
                    // WRR/RDR: responders decode the opcode under cmrom.
                    cm_nxt_s = (op_nxt_s == OP_WRR) || (op_nxt_s == OP_RDR);
                end
                SC_X2: begin
                    if (op_nxt_s == OP_SRC) begin
                        dir_nxt_s = 1'b1;
                        out_nxt_s = wdata_nxt_s[7:4];
                        cm_nxt_s  = 1'b1;
                    end else if (op_nxt_s == OP_WRR) begin
                        dir_nxt_s = 1'b1;
                        out_nxt_s = wdata_nxt_s[3:0];
                    end else begin
                        dir_nxt_s = 1'b0;
                        out_nxt_s = 4'd0;
                    end
                end
                SC_X3: begin
                    if (op_nxt_s == OP_SRC) begin
                        dir_nxt_s = 1'b1;
                        out_nxt_s = wdata_nxt_s[3:0];
                    end else begin
                        dir_nxt_s = 1'b0;
                        out_nxt_s = 4'd0;
                    end
                end
                default: begin
                    dir_nxt_s = 1'b0;
                    out_nxt_s = 4'd0;
                    cm_nxt_s  = 1'b0;
                end
            endcase
        end else begin
            dir_nxt_s = 1'b0;
            out_nxt_s = 4'd0;
            cm_nxt_s  = 1'b0;
        end
    end

    // Counter and request state; reset parks at X3 Q0 so responders see sync first.
    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
            tick_r    <= {TW{1'b0}};
            quarter_r <= 2'd0;
            sc_r      <= SC_X3;
            active_r  <= 1'b0;
            op_r      <= OP_FETCH;
            addr_r    <= 12'd0;
            wdata_r   <= 8'd0;
        end else begin
            tick_r    <= tick_nxt_s;
            quarter_r <= quarter_nxt_s;
            sc_r      <= sc_nxt_s;
            active_r  <= active_nxt_s;
            op_r      <= op_nxt_s;
            addr_r    <= addr_nxt_s;
            wdata_r   <= wdata_nxt_s;
        end
    end

    // Registered pads, ack pulse and read-data capture at the clk2 sample point.
    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
            clk1_pad  <= 1'b0;
            clk2_pad  <= 1'b0;
            sync_pad  <= 1'b0;
            cmrom_pad <= 1'b0;
            data_dir  <= 1'b0;
            data_out  <= 4'd0;
            ack       <= 1'b0;
            rdata     <= 8'd0;
        end else begin
            clk1_pad  <= (quarter_nxt_s == 2'd0);
            clk2_pad  <= (quarter_nxt_s == 2'd2);
            sync_pad  <= (sc_nxt_s == SC_X3);
            cmrom_pad <= cm_nxt_s;
            data_dir  <= dir_nxt_s;
            data_out  <= out_nxt_s;
            ack       <= ack_edge_s && active_r;
            if (sample_s && active_r) begin
                case (sc_r)
                    SC_M1:   rdata[7:4] <= data_in;
                    SC_M2:   rdata[3:0] <= data_in;
                    SC_X2:   rdata[3:0] <= (op_r == OP_RDR) ? data_in : rdata[3:0];
                    default: rdata      <= rdata;
                endcase
            end else begin
                rdata <= rdata;
            end
        end
    end

endmodule
